// File: rtl/and_arb_pkg.sv
// and_arb_pkg: shared defaults and types for the AND arbiter block.
//   WIDTH_DEF / N_REQ_DEF : default operand width and requester count
//   ID_W_DEF              : requester index width for the defaults
//   state_t               : result-register state (EMPTY / FULL)
package and_arb_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int N_REQ_DEF = 4;
  localparam int ID_W_DEF  = (N_REQ_DEF > 1) ? $clog2(N_REQ_DEF) : 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  // Index width for an arbitrary requester count (at least one bit).
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/and_array_unit.sv
// and_array_unit: WIDTH-bit bitwise AND datapath.
//   a, b : operands
//   y    : a & b
module and_array_unit #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign y[i] = a[i] & b[i];
  end
endmodule

// File: rtl/and_arb_ctrl.sv
// and_arb_ctrl: round-robin arbiter feeding one shared AND unit, with a
// single-entry result register (valid/ready on both sides).
//   clk, rst_n         : clock, async active-low reset
//   req_valid/req_a/b  : per-requester operand pairs (packed WIDTH slices)
//   req_ready          : one-hot (or zero) grant, combinational
//   res_valid/data/id  : registered result and the requester that made it
//   res_ready          : consumer accept
//   op_count           : wrapping count of accepted requests
module and_arb_ctrl
  import and_arb_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int N_REQ = N_REQ_DEF,
  localparam int ID_W  = id_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   res_valid,
  output logic [WIDTH-1:0]       res_data,
  output logic [ID_W-1:0]        res_id,
  input  logic                   res_ready,
  output logic [15:0]            op_count
);
  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   gnt_id;
  logic              found;
  logic              can_accept;
  logic              xfer;
  logic [WIDTH-1:0]  sel_a, sel_b, and_y;

  assign can_accept = !res_valid || res_ready;

  // First valid requester at or after ptr, wrapping. rst_n gates the grant
  // so nothing is offered while reset is held.
  always_comb begin
    int idx;
    idx       = 0;
    found     = 1'b0;
    gnt_id    = '0;
    req_ready = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = ID_W'(idx);
      end
    end
    if (found && can_accept && rst_n) req_ready[gnt_id] = 1'b1;
  end

  assign xfer  = |req_ready;
  assign sel_a = req_a[gnt_id*WIDTH +: WIDTH];
  assign sel_b = req_b[gnt_id*WIDTH +: WIDTH];

  and_array_unit #(.WIDTH(WIDTH)) u_and (
    .a (sel_a),
    .b (sel_b),
    .y (and_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      ptr       <= '0;
      op_count  <= '0;
    end else begin
      if (xfer) begin
        ptr      <= (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
        op_count <= op_count + 16'd1;
      end
      case (state)
        EMPTY: begin
          if (xfer) begin
            state     <= FULL;
            res_valid <= 1'b1;
            res_data  <= and_y;
            res_id    <= gnt_id;
          end
        end
        FULL: begin
          // With res_ready low there is no grant, so outputs simply hold.
          if (res_ready) begin
            if (xfer) begin
              res_data <= and_y;
              res_id   <= gnt_id;
            end else begin
              state     <= EMPTY;
              res_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= EMPTY;
          res_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/and_arb_ctrl.md
AND_ARB_CTRL -- requirements
Module: and_arb_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter N_REQ, default 4, giving the number of requesters; ID_W = clog2(N_REQ).
REQ-003 clk  in  1  single clock; all state SHALL be updated on its rising edge.
REQ-004 rst_n  in  1  one clock; reset is asynchronous and active-low.
REQ-005 req_valid  in  N_REQ  bit i high means requester i presents an operand pair.
REQ-006 req_a  in  N_REQ*WIDTH  requester i operand A in bits [i*WIDTH +: WIDTH].
REQ-007 req_b  in  N_REQ*WIDTH  requester i operand B, same slicing as req_a.
REQ-008 req_ready  out  N_REQ  grant; at most one bit set (one-hot or zero).
REQ-009 res_valid  out  1  result register holds an unconsumed result.
REQ-010 res_data  out  WIDTH  bitwise AND of the granted operand pair.
REQ-011 res_id  out  ID_W  index of the requester that produced res_data.
REQ-012 res_ready  in  1  consumer accepts the result when res_valid is also high.
REQ-013 op_count  out  16  count of accepted requests.

Function
REQ-014 can_accept SHALL be (!res_valid || res_ready); req_ready SHALL be all-zero when can_accept is 0.
REQ-015 When can_accept is 1, req_ready SHALL select the first set req_valid bit, searching round-robin from pointer ptr upward with wrap at N_REQ-1 to 0.
REQ-016 req_ready SHALL be combinational from req_valid, ptr, res_valid and res_ready, with no registered delay.
REQ-017 A transfer occurs when req_valid[i] && req_ready[i]. One cycle later, res_valid SHALL be 1, res_data SHALL be req_a[i] & req_b[i] as sampled in the transfer cycle, and res_id SHALL be i.
REQ-018 FSM states and transitions SHALL be:
- EMPTY (res_valid=0) -> FULL on transfer; otherwise stays EMPTY.
- FULL -> FULL holding outputs when res_ready=0.
- FULL -> FULL loading new data when res_ready=1 and a transfer occurs.
- FULL -> EMPTY when res_ready=1 and no transfer occurs.
REQ-019 Throughput SHALL be one result per cycle when res_ready is held high (back-to-back transfers).
REQ-020 While FULL and res_ready=0, res_data and res_id SHALL remain stable.
REQ-021 After a transfer to requester i, ptr SHALL become (i+1) mod N_REQ; without a transfer, ptr SHALL be unchanged.
REQ-022 op_count SHALL increment by 1 on each transfer and SHALL wrap from 0xFFFF to 0x0000.
REQ-023 Requesters whose req_valid is low SHALL never be granted; req_valid=0 on all requesters SHALL produce no state change except output drain.

Reset
REQ-024 Asserting rst_n low SHALL immediately clear res_valid, res_data, res_id, ptr and op_count to 0 and set the state to EMPTY.
REQ-025 req_ready SHALL be all-zero while rst_n is low.
REQ-026 Reset asserted mid-operation SHALL discard any held result with no completion signalled.
REQ-027 rst_n deassertion SHALL be synchronous to clk, provided by the reset source outside this block.

Structure
REQ-028 Package and_arb_pkg SHALL hold the WIDTH and N_REQ defaults, ID_W, and the state enum {EMPTY, FULL}.
REQ-029 The shared AND datapath SHALL be a single sub-module, and_array_unit (WIDTH-bit bitwise AND), instantiated exactly once and fed by the grant mux.
REQ-030 Round-robin selection SHALL be implemented inside and_arb_ctrl, not as a separate module.

Verification
REQ-031 Single request: req_valid=0001, a0=0xF0F0, b0=0x3C3C, res_ready=1 -> req_ready=0001 in the same cycle; next cycle res_valid=1, res_data=0x3030, res_id=0, op_count=1.
REQ-032 Fairness: req_valid=1111 held, res_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; op_count=5 after 5 cycles.
REQ-033 Backpressure: FULL with res_ready=0 for 10 cycles -> req_ready=0000 and res_data/res_id unchanged; on res_ready=1 the next grant occurs in that same cycle.
REQ-034 Pointer skip: ptr=1, req_valid=1001 -> grant 3, then grant 0.
REQ-035 Async reset: rst_n low while FULL, between clock edges -> res_valid=0, op_count=0, req_ready=0000 without waiting for a clock edge; first grant after release goes to requester 0.
REQ-036 Wrap: 65536 transfers -> op_count reads 0xFFFF after 65535 transfers, then 0x0000.
